// File: rtl/fmul_issue.sv
// Issue/collect controller around the fmul datapath stage.
// Requests are accepted over valid/ready and their operands go straight to fmul.
// Tags ride a valid/tag pipe matched to the fmul latency.
// Results land in a small result FIFO with a valid/ready output.
// Admission is credit-based, so every issued op already owns a FIFO slot.
module fmul_issue #(
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned FMUL_LAT = 1,
    parameter int unsigned DEPTH    = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_x1,
    output logic [31:0]      mul_x2,
    input  logic [31:0]      mul_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for inflight + count even in the worst case.
    localparam int unsigned CNT_W = $clog2(DEPTH + FMUL_LAT + 1);

    logic [FMUL_LAT-1:0] vld_q;
    logic [TAG_W-1:0]    tag_q [FMUL_LAT];

    logic [31:0]         mem_y_q   [DEPTH];
    logic [TAG_W-1:0]    mem_tag_q [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    inflight;

    logic in_fire;
    logic push;
    logic pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Operands go to fmul every cycle; unfired results are dropped by the valid pipe.
    assign mul_x1 = in_x1;
    assign mul_x2 = in_x2;

    assign in_fire = in_valid & in_ready;
    assign push    = vld_q[FMUL_LAT-1];
    assign pop     = out_valid & out_ready;

    // Count the valid pipe stages: ops issued whose result has not reached the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(FMUL_LAT); i++) begin
            inflight = inflight + CNT_W'(vld_q[i]);
        end
    end

    // Credit check uses registered state only, so it has no path from out_ready.
    assign in_ready  = (inflight + count_q) < CNT_W'(DEPTH);
    assign out_valid = (count_q != '0);
    assign out_y     = mem_y_q[rd_ptr_q];
    assign out_tag   = mem_tag_q[rd_ptr_q];
    assign busy      = (inflight != '0) | (count_q != '0);

    // Valid/tag pipe: stage 0 loads every edge, later stages shift.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_q <= '0;
            for (int i = 0; i < int'(FMUL_LAT); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_fire;
            tag_q[0] <= in_tag;
            for (int i = 1; i < int'(FMUL_LAT); i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // FIFO pointer and occupancy next state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; cleared on reset so out_y/out_tag read zero while empty.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_y_q[i]   <= '0;
                mem_tag_q[i] <= '0;
            end
        end else if (push) begin
            mem_y_q[wr_ptr_q]   <= mul_y;
            mem_tag_q[wr_ptr_q] <= tag_q[FMUL_LAT-1];
        end
    end

endmodule

// File: doc/fmul_issue.md
# fmul_issue

Issue/collect controller wrapped around the single-precision `fmul` datapath stage. It accepts multiply requests over a valid/ready handshake and drives the operands into `fmul`. It tracks each in-flight operation's tag through a shift pipeline matched to `fmul` latency, then captures each result into a small result FIFO with a valid/ready output. `fmul` cannot stall, so admission is credit-based: a result is never issued unless a FIFO slot is reserved for it.

## Interface
Parameters:
- `TAG_W`, default 4: width of the request tag carried alongside each operation.
- `FMUL_LAT`, default 1: register latency of `fmul`, from operands presented to `y` valid. Legal range 1..4.
- `DEPTH`, default 3: number of result FIFO entries. Must be ≥ `FMUL_LAT`+1; full throughput requires ≥ `FMUL_LAT`+2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted this cycle if `in_valid`.
- `in_x1`, `in_x2`  in  32  IEEE-754 single-precision operands.
- `in_tag`  in  `TAG_W`  request tag.
- `mul_x1`, `mul_x2`  out  32  to `fmul` `x1`/`x2`.
- `mul_y`  in  32  from `fmul` `y`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts.
- `out_y`  out  32  product.
- `out_tag`  out  `TAG_W`  tag of `out_y`.
- `busy`  out  1  any operation in flight or any result buffered.

## Operation
- Fire: `in_fire` = `in_valid` & `in_ready`; `out_fire` = `out_valid` & `out_ready`.
- Operand path: `mul_x1` = `in_x1` and `mul_x2` = `in_x2`, purely combinational and unconditional. `fmul` samples them every edge. Results of non-fired cycles are discarded by the valid pipe.
- Valid/tag pipe:
  - Consists of `FMUL_LAT` stages of {valid, tag}.
  - Stage 0 loads {`in_fire`, `in_tag`} every edge; later stages shift.
  - When the last stage is valid, `mul_y` and that tag are written into the FIFO at that edge.
- `inflight` = count of valid pipe stages; `count` = FIFO occupancy.
- `in_ready` = (`inflight` + `count`) < `DEPTH`. It is derived from registered state only, with no combinational path from `out_ready` or `in_valid`.
- FIFO:
  - Circular buffer with rd/wr pointers wrapping at `DEPTH` and a separate `count` (0..`DEPTH`).
  - `out_valid` = `count` ≠ 0; `out_y`/`out_tag` = entry at the read pointer.
  - Push and pop in the same cycle: `count` is unchanged and both pointers advance.
  - Pop on an empty FIFO is impossible; `out_ready` is ignored while `out_valid`=0.
  - Push on a full FIFO without a pop is prevented by credit. Reaching it is a design error, and the bench asserts it never occurs.
- Ordering: results leave strictly in acceptance order. No reordering, no dropping.
- `out_y`/`out_tag` hold stable while `out_valid` & !`out_ready`.
- `busy` = (`inflight` ≠ 0) | (`count` ≠ 0).
- No arithmetic on operands or results: values pass through bit-exact, and special-value handling is owned by `fmul`.

## Timing
- Reset (`rstn`=0, async) clears every pipe stage valid, pointers, `count`, and FIFO storage, so `out_y`=0, `out_tag`=0, `out_valid`=0, `busy`=0, `in_ready`=1 while in reset.
- Reset mid-operation: in-flight operations are lost. An `fmul` output arriving after release is not captured, because its pipe valid was cleared.
- Latency: `in_fire` at cycle t gives `out_valid` at cycle t+`FMUL_LAT`+1 when the FIFO is empty.
- Throughput: one op per cycle sustained when `out_ready`=1 and `DEPTH` ≥ `FMUL_LAT`+2.
- Credit release: a pop at edge e raises `in_ready` in the cycle following e, never in the same cycle.

## Test plan
- **Reset:** assert `rstn`=0 with 2 ops in flight, release → `out_valid`=0, `busy`=0, `in_ready`=1. No result appears in the following 5 cycles.
- **Single op:** `in_x1`=0x3FC00000, `in_x2`=0x40000000, `in_tag`=5, `out_ready`=1 → `out_valid` exactly 2 cycles after fire, `out_y`=0x40400000, `out_tag`=5, then `busy`=0.
- **Streaming:** 8 back-to-back ops with tags 0..7, `out_ready`=1 → `in_ready` never drops, one result per cycle, tags 0..7 in order.
- **Backpressure:** `out_ready`=0 with `in_valid` held → exactly 3 accepted, then `in_ready`=0. `out_y`/`out_tag` stable. Raising `out_ready` drains all 3 in order, and `in_ready` returns the cycle after the first pop.
- **Sign path:** 0xC0000000 × 0x3F800000 → `out_y`=0xC0000000.
- **Random:** 1000 ops with random `in_valid`/`out_ready` (50%), compared against a software `fmul` model plus tag queue → all results bit-exact and in order. FIFO overflow assertion never fires.
